imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-memory request unit sitting directly upstream of the fetch stage. It owns the fetch PC and issues word requests on a valid/ready instruction bus. It tracks in-order outstanding responses and buffers returned instructions with their PC in a small FIFO. On a branch/jump redirect it kills in-flight and buffered work and restarts from the new address.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, total slots (outstanding requests + buffered instructions); power of two, ≥2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 00)
- ireq_valid  out  1  request on instruction bus
- ireq_addr  out  32  word address of request
- ireq_ready  in  1  bus accepts request
- iresp_valid  in  1  response data valid (in request order, ≥1 cycle after acceptance)
- iresp_data  in  32  instruction word
- out_valid  out  1  instruction available to fetch
- out_pc  out  32  PC of out_instr
- out_instr  out  32  instruction word
- out_ready  in  1  fetch consumes this cycle

## Operation
- State: req_pc (32b); pending queue (DEPTH entries of {pc, live}); instruction FIFO (DEPTH entries of {pc, instr}); pending_cnt, fifo_cnt.
- Credit: ireq_valid = (pending_cnt + fifo_cnt < DEPTH), from registered counts only; ireq_addr = req_pc.
- Request handshake (ireq_valid & ireq_ready): push {req_pc, live=~redirect_valid} to pending; req_pc += 4 (mod 2^32 wrap).
- Response (iresp_valid, pending non-empty): pop pending head; if head.live and no redirect this cycle, push {head.pc, iresp_data} to FIFO; else discard. iresp_valid with pending empty is ignored.
- Output: out_valid = fifo non-empty & ~redirect_valid; out_pc/out_instr = FIFO head; pop on out_valid & out_ready.
- Redirect: next cycle req_pc = {redirect_pc[31:2],2'b00}; FIFO emptied; all pending entries' live bits cleared (they still hold credit until their responses return). Redirect overrides the PC increment of a same-cycle request handshake.
- Total occupancy invariant: pending_cnt + fifo_cnt ≤ DEPTH at all times; never push a full queue.

## Timing
- Reset (async assert): req_pc = RESET_PC, counts = 0, out_valid = 0, ireq_valid = 0 while reset high; first cycle after release ireq_valid = 1, ireq_addr = RESET_PC.
- Response at cycle N → out_valid at N+1 (FIFO registered).
- With 1-cycle bus latency, ireq_ready = 1, out_ready = 1: one instruction per cycle sustained; first out_valid 2 cycles after first acceptance.
- out_valid held with stable out_pc/out_instr until consumed or redirect.
- ireq_valid may drop/addr may change without handshake only on redirect.
- Redirect cycle: out_valid = 0; first post-redirect request issued the next cycle if credit exists, else waits for stale responses to drain.
- Reset mid-operation: everything cleared; late bus responses after reset are ignored (pending empty).

## Test plan
- Reset release, 1-cycle memory returning addr as data, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles, out_instr = out_pc.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 requests accepted, out_valid held at pc 0, ireq_valid=0 until pop.
- ireq_ready=0 for 3 cycles -> ireq_addr stable at 0; then stream resumes without gap or duplicate.
- Redirect to 0x100 with 2 requests outstanding (3-cycle latency) -> both responses dropped, next out_pc = 0x100, then 0x104.
- Redirect to 0x203 in same cycle as request handshake and response -> accepted request killed, response dropped, next ireq_addr = 0x200.
- Back-to-back redirects 0x40 then 0x80 with stale responses pending -> only pc 0x80 onward appears at output.
- req_pc 0xFFFF_FFFC -> next request address 0x0000_0000.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Bundles the three handshakes around the fetch request unit: redirect in,
// instruction-bus request/response, and the instruction stream to fetch.
interface imem_fetch_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;

    logic        iresp_valid;
    logic [31:0] iresp_data;

    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    // Fetch-controller side: issues bus requests and produces instructions.
    modport master (
        input  redirect_valid, redirect_pc,
        output ireq_valid, ireq_addr,
        input  ireq_ready,
        input  iresp_valid, iresp_data,
        output out_valid, out_pc, out_instr,
        input  out_ready
    );

    // Environment side: memory bus, branch unit and fetch stage.
    modport slave (
        output redirect_valid, redirect_pc,
        input  ireq_valid, ireq_addr,
        output ireq_ready,
        output iresp_valid, iresp_data,
        input  out_valid, out_pc, out_instr,
        output out_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory request unit. Owns the fetch PC, issues word requests
// while credit remains, tracks in-order outstanding responses, and buffers
// returned instructions with their PC. A redirect kills every in-flight and
// buffered instruction; killed requests keep their credit until they return.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    imem_fetch_ctrl_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      req_pc;

    logic [31:0]      pend_pc [DEPTH];
    logic [DEPTH-1:0] pend_live;
    logic [DEPTH-1:0] pend_live_next;
    logic [PW-1:0]    pend_wr;
    logic [PW-1:0]    pend_rd;
    logic [CW-1:0]    pending_cnt;

    logic [31:0]      fifo_pc    [DEPTH];
    logic [31:0]      fifo_instr [DEPTH];
    logic [PW-1:0]    fifo_wr;
    logic [PW-1:0]    fifo_rd;
    logic [CW-1:0]    fifo_cnt;

    logic [CW:0]      occupancy;
    logic             credit;
    logic             req_fire;
    logic             resp_fire;
    logic             fifo_push;
    logic             fifo_pop;

    // Credit counts both in-flight requests and buffered instructions, so a
    // response always finds a free FIFO slot.
    assign occupancy = {1'b0, pending_cnt} + {1'b0, fifo_cnt};
    assign credit    = occupancy < (CW + 1)'(DEPTH);

    assign bus.ireq_valid = credit & ~reset;
    assign bus.ireq_addr  = req_pc;
    assign bus.out_valid  = (fifo_cnt != '0) & ~bus.redirect_valid;
    assign bus.out_pc     = fifo_pc[fifo_rd];
    assign bus.out_instr  = fifo_instr[fifo_rd];

    assign req_fire  = bus.ireq_valid & bus.ireq_ready;
    assign resp_fire = bus.iresp_valid & (pending_cnt != '0);
    assign fifo_push = resp_fire & pend_live[pend_rd] & ~bus.redirect_valid;
    assign fifo_pop  = bus.out_valid & bus.out_ready;

    // Fetch PC: redirect wins over the increment of a same-cycle handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            req_pc <= {bus.redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            req_pc <= req_pc + 32'd4;
        end
    end

    // Live bits: a redirect kills everything in flight, including a request
    // accepted in the redirect cycle itself.
    always_comb begin
        pend_live_next = bus.redirect_valid ? '0 : pend_live;
        if (req_fire) begin
            pend_live_next[pend_wr] = ~bus.redirect_valid;
        end
    end

    // Pending-queue pointers, count and live flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_wr     <= '0;
            pend_rd     <= '0;
            pending_cnt <= '0;
            pend_live   <= '0;
        end else begin
            if (req_fire) begin
                pend_wr <= pend_wr + PW'(1);
            end
            if (resp_fire) begin
                pend_rd <= pend_rd + PW'(1);
            end
            pending_cnt <= pending_cnt + CW'(req_fire) - CW'(resp_fire);
            pend_live   <= pend_live_next;
        end
    end

    // Pending-queue PC storage; needs no reset because the count guards it.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pend_pc[pend_wr] <= req_pc;
        end
    end

    // Instruction FIFO pointers and count; redirect empties it in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else if (bus.redirect_valid) begin
            fifo_rd  <= fifo_wr;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                fifo_wr <= fifo_wr + PW'(1);
            end
            if (fifo_pop) begin
                fifo_rd <= fifo_rd + PW'(1);
            end
            fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    // Instruction FIFO storage: response pairs with the PC of its request.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
            fifo_instr[fifo_wr] <= bus.iresp_data;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: a latency-programmable in-order memory model
// plus a queue-based reference of the fetch unit's observable behaviour.
module tb_imem_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    typedef struct {
        logic [31:0] pc;
        bit          live;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } inst_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk;
    logic reset;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_compared;
    int n_mismatched;
    int cyc;
    int hs_count;
    int first_out;
    bit gaps;
    bit stale;
    logic [31:0] salt;

    pend_t       m_pend[$];
    inst_t       m_fifo[$];
    logic [31:0] m_pc;
    mreq_t       mem_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a salted image of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    // Single comparison point; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the reference, then
    // advance the reference and the memory model by the cycle's events.
    task automatic applyStimulus(input bit in_rst, input bit rdy, input bit ordy,
                                 input bit redir, input logic [31:0] rpc, input int lat);
        bit          presented;
        bit          exp_iv;
        bit          exp_ov;
        bit          req;
        bit          dut_hs;
        pend_t       h;
        inst_t       e;
        mreq_t       m;
        @(negedge clk);
        reset              = in_rst;
        bus.ireq_ready     = rdy;
        bus.out_ready      = ordy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        presented          = 1'b0;
        if (in_rst) begin
            bus.iresp_valid = $urandom_range(0, 1);
            bus.iresp_data  = 32'hDEAD_BEEF;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc && (!gaps || $urandom_range(0, 3) != 0)) begin
            presented       = 1'b1;
            bus.iresp_valid = 1'b1;
            bus.iresp_data  = mem_word(mem_q[0].addr);
        end else if (stale) begin
            bus.iresp_valid = 1'b1;
            bus.iresp_data  = 32'hDEAD_BEEF;
        end else begin
            bus.iresp_valid = 1'b0;
            bus.iresp_data  = $urandom;
        end
        #1;

        exp_iv = !in_rst && (m_pend.size() + m_fifo.size() < DEPTH);
        exp_ov = !in_rst && (m_fifo.size() > 0) && !redir;
        checkOutput("ireq_valid", {31'b0, bus.ireq_valid}, {31'b0, exp_iv});
        if (exp_iv) checkOutput("ireq_addr", bus.ireq_addr, m_pc);
        checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_ov});
        if (exp_ov) begin
            checkOutput("out_pc", bus.out_pc, m_fifo[0].pc);
            checkOutput("out_instr", bus.out_instr, m_fifo[0].instr);
        end
        if (!in_rst && bus.out_valid && first_out < 0) first_out = cyc;

        dut_hs = bus.ireq_valid && rdy;
        if (dut_hs) hs_count++;

        if (in_rst) begin
            m_pend.delete();
            m_fifo.delete();
            m_pc = RESET_PC;
            mem_q.delete();
            stale = 1'b1;
        end else begin
            stale = 1'b0;
            req = exp_iv && rdy;
            if (exp_ov && ordy) void'(m_fifo.pop_front());
            if (bus.iresp_valid && m_pend.size() > 0) begin
                h = m_pend.pop_front();
                if (h.live && !redir) begin
                    e.pc    = h.pc;
                    e.instr = mem_word(h.pc);
                    m_fifo.push_back(e);
                end
            end
            if (redir) begin
                m_fifo.delete();
                foreach (m_pend[i]) m_pend[i].live = 1'b0;
            end
            if (req) begin
                h.pc   = m_pc;
                h.live = !redir;
                m_pend.push_back(h);
            end
            if (redir) m_pc = {rpc[31:2], 2'b00};
            else if (req) m_pc = m_pc + 32'd4;

            if (presented) void'(mem_q.pop_front());
            if (dut_hs) begin
                m.addr = bus.ireq_addr;
                m.due  = cyc + lat;
                mem_q.push_back(m);
            end
        end
        cyc++;
    endtask

    task automatic runIdle(input int n, input bit rdy, input bit ordy, input int lat);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, rdy, ordy, 1'b0, 32'h0, lat);
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1);
    endtask

    initial begin
        int rel_cyc;
        n_compared     = 0;
        n_mismatched   = 0;
        cyc            = 0;
        hs_count       = 0;
        first_out      = -1;
        gaps           = 1'b0;
        stale          = 1'b0;
        salt           = 32'h0;
        m_pc           = RESET_PC;
        reset          = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.ireq_ready     = 1'b0;
        bus.iresp_valid    = 1'b0;
        bus.iresp_data     = 32'h0;
        bus.out_ready      = 1'b0;

        $display("[TB] reset release and streaming");
        doReset(3);
        first_out = -1;
        rel_cyc   = cyc;
        runIdle(8, 1'b1, 1'b1, 1);
        checkOutput("first_out_latency", 32'(first_out - rel_cyc), 32'd2);

        $display("[TB] fetch stalled, credit limit");
        doReset(2);
        hs_count = 0;
        runIdle(10, 1'b1, 1'b0, 1);
        checkOutput("credit_limit", 32'(hs_count), 32'(DEPTH));
        runIdle(6, 1'b1, 1'b1, 1);

        $display("[TB] bus not ready");
        runIdle(3, 1'b0, 1'b1, 1);
        runIdle(6, 1'b1, 1'b1, 1);

        $display("[TB] redirect with slow memory");
        runIdle(5, 1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 3);
        runIdle(12, 1'b1, 1'b1, 3);

        $display("[TB] redirect coincident with handshake and response");
        runIdle(4, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203, 1);
        runIdle(6, 1'b1, 1'b1, 1);

        $display("[TB] back-to-back redirects");
        runIdle(4, 1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 3);
        runIdle(12, 1'b1, 1'b1, 3);

        $display("[TB] address wrap");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF6, 1);
        runIdle(8, 1'b1, 1'b1, 1);

        $display("[TB] reset mid-operation");
        runIdle(4, 1'b1, 1'b1, 3);
        doReset(2);
        runIdle(8, 1'b1, 1'b1, 2);

        $display("[TB] randomized traffic");
        doReset(2);
        salt = $urandom;
        gaps = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'b0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom,
                          $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
